// File: rtl/sys_run_controller.sv
// Session sequencer around the single-cycle MIPS core: loads data and program
// images through the core's reset-time write ports, runs it, then dumps data memory.
module sys_run_controller #(
  parameter int unsigned TIMEOUT      = 100000,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned INST_SCRATCH = 1023,
  parameter int unsigned DATA_SCRATCH = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_len,
  input  logic [15:0] inst_len,
  input  logic [31:0] dump_base,
  input  logic [15:0] dump_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        busy,
  output logic        sess_done,
  output logic        timeout_err,
  output logic [31:0] run_cycles,
  output logic        proc_rst,
  output logic [31:0] inst_write_addr,
  output logic [31:0] inst_data_in,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] proc_out,
  input  logic        proc_done
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_DATA = 3'd1;
  localparam logic [2:0] ST_LOAD_INST = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_DUMP      = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

  logic [2:0]  state;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [15:0] data_len_q;
  logic [15:0] inst_len_q;
  logic [15:0] dump_len_q;
  logic [31:0] dump_base_q;
  logic [31:0] lat_cnt;

  assign idx_inc   = idx + 16'd1;
  assign s_ready   = (state == ST_LOAD_DATA) || (state == ST_LOAD_INST);
  assign busy      = (state != ST_IDLE);
  assign sess_done = (state == ST_FINISH);
  // The core must stay out of reset through DUMP so it keeps done high and serves reads.
  assign proc_rst  = !((state == ST_RUN) || (state == ST_DUMP));

  always_comb begin
    inst_write_addr = 32'(INST_SCRATCH);
    inst_data_in    = '0;
    mem_write_addr  = 32'(DATA_SCRATCH);
    mem_data_in     = '0;
    if (state == ST_LOAD_DATA && s_valid) begin
      mem_write_addr = {16'd0, idx};
      mem_data_in    = s_data;
    end else if (state == ST_LOAD_INST && s_valid) begin
      inst_write_addr = {16'd0, idx};
      inst_data_in    = s_data;
    end else if (state == ST_DUMP) begin
      mem_write_addr = dump_base_q + {16'd0, idx};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      data_len_q  <= '0;
      inst_len_q  <= '0;
      dump_len_q  <= '0;
      dump_base_q <= '0;
      lat_cnt     <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      timeout_err <= 1'b0;
      run_cycles  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            data_len_q  <= data_len;
            inst_len_q  <= inst_len;
            dump_len_q  <= dump_len;
            dump_base_q <= dump_base;
            timeout_err <= 1'b0;
            run_cycles  <= '0;
            idx         <= '0;
            if (data_len != 16'd0)      state <= ST_LOAD_DATA;
            else if (inst_len != 16'd0) state <= ST_LOAD_INST;
            else                        state <= ST_RUN;
          end
        end
        ST_LOAD_DATA: begin
          if (s_valid) begin
            if (idx_inc == data_len_q) begin
              idx   <= '0;
              state <= (inst_len_q != 16'd0) ? ST_LOAD_INST : ST_RUN;
            end else begin
              idx <= idx_inc;
            end
          end
        end
        ST_LOAD_INST: begin
          if (s_valid) begin
            if (idx_inc == inst_len_q) begin
              idx   <= '0;
              state <= ST_RUN;
            end else begin
              idx <= idx_inc;
            end
          end
        end
        ST_RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (proc_done) begin
            lat_cnt <= '0;
            state   <= (dump_len_q != 16'd0) ? ST_DUMP : ST_FINISH;
          end else if (run_cycles + 32'd1 == 32'(TIMEOUT)) begin
            timeout_err <= 1'b1;
            state       <= ST_FINISH;
          end
        end
        ST_DUMP: begin
          // Address is held for RD_LAT cycles, then read data is captured and presented.
          if (!m_valid) begin
            if (lat_cnt == 32'(RD_LAT)) begin
              m_data  <= proc_out;
              m_valid <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt + 32'd1;
            end
          end else if (m_ready) begin
            m_valid <= 1'b0;
            lat_cnt <= '0;
            if (idx_inc == dump_len_q) state <= ST_FINISH;
            else                       idx   <= idx_inc;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_run_controller.md
# sys_run_controller

Session sequencer wrapped around the single-cycle MIPS processor core. It holds the core in reset while it streams a data image and a program image from a host into the core's data and instruction memories through the memories' reset-time write ports. It then releases reset and counts cycles until the core raises `proc_done` or a timeout expires. Finally it streams a window of data memory back to the host.

## Interface
Parameters:
- `TIMEOUT`, default 100000: maximum run cycles before the run is aborted.
- `RD_LAT`, default 1: cycles from `mem_write_addr` to valid `proc_out`.
- `INST_SCRATCH`, default 1023: instruction address absorbing unavoidable writes.
- `DATA_SCRATCH`, default 1023: data address absorbing unavoidable writes.

Ports:
- Reset is `rst`, synchronous, active-high; clock is `clk`.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle session request; sampled only in IDLE.
- `data_len`  in  16  data words to load; latched at start.
- `inst_len`  in  16  instruction words to load; latched at start.
- `dump_base`  in  32  first data address to read back; latched at start.
- `dump_len`  in  16  words to read back; latched at start.
- `s_valid`  in  1  host load word valid.
- `s_ready`  out  1  load word accepted.
- `s_data`  in  32  load word.
- `m_valid`  out  1  dump word valid.
- `m_ready`  in  1  host accepts dump word.
- `m_data`  out  32  dump word.
- `busy`  out  1  session in progress.
- `sess_done`  out  1  one-cycle pulse at session end.
- `timeout_err`  out  1  sticky; set on timeout, cleared at next start.
- `run_cycles`  out  32  cycles spent in RUN for the last session.
- `proc_rst`  out  1  core reset.
- `inst_write_addr`  out  32  core instruction-memory write address.
- `inst_data_in`  out  32  core instruction-memory write data.
- `mem_write_addr`  out  32  core data-memory write/read address.
- `mem_data_in`  out  32  core data-memory write data.
- `proc_out`  in  32  core data-memory read data.
- `proc_done`  in  1  core halted.

## Operation
- The core writes both memories on every cycle in which `proc_rst` is high. Whenever `proc_rst` is high, any memory not being loaded has its address driven to its SCRATCH address and its data driven to 0.
- Reset values:
  - state IDLE, `proc_rst`=1, `s_ready`=0, `m_valid`=0, `m_data`=0.
  - `busy`=0, `sess_done`=0, `timeout_err`=0, `run_cycles`=0.
  - `inst_write_addr`=`INST_SCRATCH`, `mem_write_addr`=`DATA_SCRATCH`, both write-data outputs 0.
- IDLE: `proc_rst`=1. On `start`, latch all lengths, clear `timeout_err` and `run_cycles`, zero the index counter, and go to LOAD_DATA.
- LOAD_DATA: `s_ready`=1.
  - On each handshake, `mem_write_addr`=index and `mem_data_in`=`s_data` for that cycle, then the index increments.
  - After `data_len` words, zero the index and go to LOAD_INST. If `data_len`=0, skip directly to LOAD_INST.
- LOAD_INST: same as LOAD_DATA, using the instruction write port with `inst_len`. When done (or if `inst_len`=0), go to RUN.
- With no handshake in a LOAD state, both addresses are at scratch.
- RUN: `proc_rst`=0; `run_cycles` increments each cycle.
  - If `proc_done`=1, go to DUMP.
  - Otherwise, when `run_cycles` reaches `TIMEOUT`, set `timeout_err`, assert `proc_rst`, and go to FINISH.
- DUMP: `proc_rst` stays 0 so the core keeps `done` high, and its data read port follows `mem_write_addr`.
  - Sub-steps: drive `dump_base`+index, wait `RD_LAT` cycles, capture `proc_out` into `m_data`, then assert `m_valid` until `m_ready`.
  - After the handshake the index increments. After `dump_len` words go to FINISH. If `dump_len`=0, go directly to FINISH.
- FINISH: assert `proc_rst` and pulse `sess_done`, then return to IDLE.
- `busy` = (state ≠ IDLE).
- Address arithmetic is 32-bit and wraps modulo 2^32. Lengths are unsigned.

## Timing
- `start` to first `s_ready`: 1 cycle.
- One load word is accepted per cycle when `s_valid` is held.
- RUN is entered the cycle after the last instruction handshake. `proc_rst` falls in that same cycle.
- Each dump word takes `RD_LAT`+2 cycles minimum.
- `m_data` must stay stable while `m_valid`=1 and `m_ready`=0.
- `start` is ignored while `busy`.
- `rst` in any state: next cycle, all outputs are at reset values and the core is held in reset. Partial loads are not resumed.

## Test plan
- Load 3 data words (5,7,0) and a 4-instruction program whose result lands at address 2; `dump_base`=2, `dump_len`=1 -> `m_data`=12, `sess_done` pulses once, `timeout_err`=0.
- `s_valid` toggles every other cycle during load -> writes only on handshake cycles; scratch addresses are driven on idle cycles; final memory contents are identical to the contiguous load.
- `TIMEOUT`=20 with a program that never reaches the halt PC -> `timeout_err`=1 after 20 RUN cycles, `run_cycles`=20, no `m_valid`, return to IDLE.
- `dump_len`=4 with `m_ready` stalled 3 cycles on word 1 -> `m_data` holds; words arrive in address order.
- `data_len`=0, `dump_len`=0 -> LOAD_DATA and DUMP are skipped; `sess_done` asserts directly after `proc_done`.
- `rst` asserted mid LOAD_INST; then a new `start` -> the full session completes correctly and `start` during `busy` has no effect.
